// File: rtl/bit_serial_subtractor_if.sv
// Operand and result handshake bundle for the bit-serial subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b - bin: one full-subtractor cell, registered borrow, LSB first.
// All handshake outputs are registered; nothing combinational reaches the ports.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serial_subtractor_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic             br;
  logic             br_nx;
  logic             d;
  logic             a0;
  logic             b0;

  // Written as shift-then-insert so WIDTH=1 needs no degenerate slice.
  always_comb begin
    a0             = a_sh[0];
    b0             = b_sh[0];
    d              = a0 ^ b0 ^ br;
    br_nx          = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nx         = res >> 1;
    res_nx[WIDTH-1] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      res          <= '0;
      br           <= 1'b0;
      io.diff      <= '0;
      io.bout      <= 1'b0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_sh        <= io.a;
            b_sh        <= io.b;
            br          <= io.bin;
            cnt         <= '0;
            state       <= RUN;
            io.in_ready <= 1'b0;
            io.busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nx;
          res  <= res_nx;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            io.diff      <= res_nx;
            io.bout      <= br_nx;
            io.out_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            io.busy      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboarded bench: directed WIDTH=8 scenarios plus exhaustive WIDTH=4 and WIDTH=1 sweeps.
module tb_bit_serial_subtractor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst4, rst1;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit done8 = 0, done4 = 0, done1 = 0;

  bit_serial_subtractor_if #(.WIDTH(8)) i8 ();
  bit_serial_subtractor_if #(.WIDTH(4)) i4 ();
  bit_serial_subtractor_if #(.WIDTH(1)) i1 ();

  bit_serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .io(i8));
  bit_serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst4), .io(i4));
  bit_serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst1), .io(i1));

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got result 0x%0h, expected none", name, act);
  endtask

  // Monitors: pop one expectation per completed result handshake.
  always @(negedge clk) begin
    if (!rst8 && i8.out_valid && i8.out_ready) begin
      if (q8.size() == 0) spurious("w8 result", {i8.bout, i8.diff});
      else chk("w8 result", {i8.bout, i8.diff}, q8.pop_front());
    end
    if (!rst4 && i4.out_valid && i4.out_ready) begin
      if (q4.size() == 0) spurious("w4 result", {i4.bout, i4.diff});
      else chk("w4 result", {i4.bout, i4.diff}, q4.pop_front());
    end
    if (!rst1 && i1.out_valid && i1.out_ready) begin
      if (q1.size() == 0) spurious("w1 result", {i1.bout, i1.diff});
      else chk("w1 result", {i1.bout, i1.diff}, q1.pop_front());
    end
  end

  // Entered at a negedge with the DUT idle and out_ready=1; returns at a negedge, idle again.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [8:0] want, input string nm);
    int k;
    chk({nm, " in_ready before"}, i8.in_ready, 1);
    q8.push_back(want);
    i8.a = a; i8.b = b; i8.bin = bin; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (i8.out_valid) break;
      if (k == 2) begin
        chk({nm, " in_ready in run"}, i8.in_ready, 0);
        chk({nm, " busy in run"}, i8.busy, 1);
      end
    end
    chk({nm, " latency"}, k, 9);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " in_ready after"}, i8.in_ready, 1);
    chk({nm, " out_valid after"}, i8.out_valid, 0);
  endtask

  initial begin : w8
    int k;
    bit seen;
    int unsigned t[3];
    logic [7:0] va[3], vb[3];
    logic       vbin[3];
    logic [8:0] vexp[3];

    rst8 = 1'b1;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0; i8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w8 reset in_ready", i8.in_ready, 1);
    chk("w8 reset out_valid", i8.out_valid, 0);
    chk("w8 reset busy", i8.busy, 0);
    chk("w8 reset diff/bout", {i8.bout, i8.diff}, 0);
    rst8 = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, 9'h01E, "basic");
    op8(8'h00, 8'h01, 1'b0, 9'h1FF, "wrap 0-1");
    op8(8'h80, 8'h7F, 1'b1, 9'h000, "80-7f-1");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ff-ff-1");

    // Backpressure in DONE with in_valid and operands wiggling.
    i8.out_ready = 1'b0;
    q8.push_back(9'h022);
    i8.a = 8'h33; i8.b = 8'h11; i8.bin = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    seen = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i8.out_valid) begin seen = 1; break; end
    end
    chk("bp reach done", seen, 1);
    repeat (5) begin
      @(posedge clk); #1;
      i8.in_valid = ~i8.in_valid;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom);
      @(negedge clk);
      chk("bp held result", {i8.bout, i8.diff}, 9'h022);
      chk("bp out_valid", i8.out_valid, 1);
      chk("bp in_ready", i8.in_ready, 0);
    end
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp in_ready after", i8.in_ready, 1);
    chk("bp busy after", i8.busy, 0);

    // Reset on the 4th RUN edge discards the operation.
    i8.a = 8'h77; i8.b = 8'h11; i8.bin = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(negedge clk);
    chk("rst in_ready", i8.in_ready, 1);
    chk("rst busy", i8.busy, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (i8.out_valid) seen = 1;
    end
    chk("rst no out_valid", seen, 0);
    op8(8'h10, 8'h01, 1'b0, 9'h00F, "after rst");

    // Back-to-back: in_valid held high, out_ready=1.
    va[0] = 8'hC3; vb[0] = 8'h41; vbin[0] = 1'b0; vexp[0] = 9'h082;
    va[1] = 8'h12; vb[1] = 8'h34; vbin[1] = 1'b0; vexp[1] = 9'h1DE;
    va[2] = 8'hA0; vb[2] = 8'h0F; vbin[2] = 1'b1; vexp[2] = 9'h090;
    for (int i = 0; i < 3; i++) begin
      q8.push_back(vexp[i]);
      i8.a = va[i]; i8.b = vb[i]; i8.bin = vbin[i]; i8.in_valid = 1'b1;
      for (k = 0; k < 40 && !i8.in_ready; k++) @(negedge clk);
      chk("b2b accept", i8.in_ready, 1);
      @(posedge clk); #1;
      t[i] = cyc;
    end
    i8.in_valid = 1'b0;
    chk("b2b spacing 0-1", t[1] - t[0], 10);
    chk("b2b spacing 1-2", t[2] - t[1], 10);
    for (k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
    chk("w8 drain", q8.size(), 0);
    done8 = 1;
  end

  initial begin : w4
    int k;
    rst4 = 1'b1;
    i4.in_valid = 1'b0; i4.a = '0; i4.b = '0; i4.bin = 1'b0; i4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w4 reset in_ready", i4.in_ready, 1);
    rst4 = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          q4.push_back(5'(a - b - c));
          i4.a = 4'(a); i4.b = 4'(b); i4.bin = 1'(c); i4.in_valid = 1'b1;
          for (k = 0; k < 20 && !i4.in_ready; k++) @(negedge clk);
          if (!i4.in_ready) chk("w4 accept timeout", i4.in_ready, 1);
          @(posedge clk); #1;
        end
    i4.in_valid = 1'b0;
    for (k = 0; k < 40 && q4.size() != 0; k++) @(negedge clk);
    chk("w4 drain", q4.size(), 0);
    done4 = 1;
  end

  initial begin : w1
    int k;
    rst1 = 1'b1;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.bin = 1'b0; i1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w1 reset in_ready", i1.in_ready, 1);
    rst1 = 1'b0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++) begin
          q1.push_back(2'(a - b - c));
          i1.a = 1'(a); i1.b = 1'(b); i1.bin = 1'(c); i1.in_valid = 1'b1;
          for (k = 0; k < 20 && !i1.in_ready; k++) @(negedge clk);
          if (!i1.in_ready) chk("w1 accept timeout", i1.in_ready, 1);
          @(posedge clk); #1;
        end
    i1.in_valid = 1'b0;
    for (k = 0; k < 40 && q1.size() != 0; k++) @(negedge clk);
    chk("w1 drain", q1.size(), 0);
    done1 = 1;
  end

  initial begin
    wait (done8 && done4 && done1);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got unfinished run, expected completion");
    $fatal(1, "timeout");
  end
endmodule
